// File: rtl/count_checker.sv
// count_checker: receive-side integrity monitor for a free-running binary up-counter.
// It samples the observed count on valid cycles and locks onto the +1 mod 2^WIDTH sequence.
// Once locked, it reports wraps, counter restarts and sequence errors.
// It keeps saturating tallies of errors and wraps.
// Optional feature macro: COUNT_CHECK_HOLD_EN. When it is defined, a repeated value is
// treated as a stalled counter and ignored instead of being flagged as a mismatch.
module count_checker #(
  parameter int WIDTH   = 4,
  parameter int LOCK_N  = 4,
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   count_in,
  input  logic               count_vld,
  input  logic               clear,
  output logic               locked,
  output logic               err_pulse,
  output logic               wrap_pulse,
  output logic               rst_pulse,
  output logic [TALLY_W-1:0] err_count,
  output logic [TALLY_W-1:0] wrap_count
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL     = '1;
  localparam logic [7:0]       LOCK_TARGET = 8'(LOCK_N);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [7:0]       run;
  logic [WIDTH-1:0] expected;
  logic             match;
  logic             hold;

  assign expected = prev + WIDTH'(1);
  assign match    = (count_in == expected);

`ifdef COUNT_CHECK_HOLD_EN
  assign hold = (count_in == prev);
`else
  assign hold = 1'b0;
`endif

  // Sequence tracker: state machine, last sample, run length, pulses and saturating tallies
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      rst_pulse  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      rst_pulse  <= 1'b0;
      if (count_vld) begin
        prev <= count_in;
        case (state)
          IDLE: begin
            state <= ACQ;
            run   <= '0;
          end
          ACQ: begin
            if (!hold) begin
              if (match) begin
                if (run + 8'd1 == LOCK_TARGET) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                  run    <= '0;
                end else begin
                  run <= run + 8'd1;
                end
              end else begin
                run <= '0;
              end
            end
          end
          LOCKED: begin
            if (!hold) begin
              if (match) begin
                if (prev == MAX_VAL) begin
                  wrap_pulse <= 1'b1;
                  if (wrap_count != '1) begin
                    wrap_count <= wrap_count + TALLY_W'(1);
                  end
                end
              end else begin
                state  <= ACQ;
                locked <= 1'b0;
                run    <= '0;
                if (count_in == '0) begin
                  rst_pulse <= 1'b1;
                end else begin
                  err_pulse <= 1'b1;
                  if (err_count != '1) begin
                    err_count <= err_count + TALLY_W'(1);
                  end
                end
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
            run    <= '0;
          end
        endcase
      end
      if (clear) begin
        err_count  <= '0;
        wrap_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: randomized and directed stimulus for count_checker.
// A behavioural model tracks the last valid sample, the good-step streak, and
// unbounded event totals. Expected tallies are those totals clipped to the tally width.
module tb_count_checker;

  localparam int WIDTH   = 4;
  localparam int LOCK_N  = 4;
  localparam int TALLY_W = 8;
  localparam int MAXV    = (1 << WIDTH) - 1;
  localparam int TMAX    = (1 << TALLY_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [WIDTH-1:0]   count_in;
  logic               count_vld;
  logic               clear;
  logic               locked;
  logic               err_pulse;
  logic               wrap_pulse;
  logic               rst_pulse;
  logic [TALLY_W-1:0] err_count;
  logic [TALLY_W-1:0] wrap_count;

  int errors = 0;
  int checks = 0;

  // Model state: whether any sample has been seen since reset, lock status,
  // last valid value, streak of good steps, and raw event totals
  bit m_seen;
  bit m_locked;
  int m_last;
  int m_streak;
  int m_errs;
  int m_wraps;
  bit e_err;
  bit e_wrap;
  bit e_rst;
  bit cmp_en = 1'b0;

  count_checker #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .TALLY_W(TALLY_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .count_vld  (count_vld),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .rst_pulse  (rst_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int clip(input int v);
    return (v > TMAX) ? TMAX : v;
  endfunction

  task automatic modelReset();
    m_seen   = 1'b0;
    m_locked = 1'b0;
    m_last   = 0;
    m_streak = 0;
    m_errs   = 0;
    m_wraps  = 0;
    e_err    = 1'b0;
    e_wrap   = 1'b0;
    e_rst    = 1'b0;
  endtask

  // Expected outputs after the next rising edge, given this cycle's inputs
  task automatic modelStep(input bit vld, input int cin, input bit clr);
    int nxt;
    e_err  = 1'b0;
    e_wrap = 1'b0;
    e_rst  = 1'b0;
    if (vld) begin
      nxt = (m_last + 1) % (MAXV + 1);
      if (!m_seen) begin
        m_seen   = 1'b1;
        m_streak = 0;
      end
`ifdef COUNT_CHECK_HOLD_EN
      else if (cin == m_last) begin
        m_streak = m_streak;
      end
`endif
      else if (!m_locked) begin
        if (cin == nxt) begin
          m_streak++;
          if (m_streak == LOCK_N) begin
            m_locked = 1'b1;
            m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end else if (cin == nxt) begin
        if (m_last == MAXV) begin
          e_wrap = 1'b1;
          m_wraps++;
        end
      end else begin
        m_locked = 1'b0;
        m_streak = 0;
        if (cin == 0) begin
          e_rst = 1'b1;
        end else begin
          e_err = 1'b1;
          m_errs++;
        end
      end
      m_last = cin;
    end
    if (clr) begin
      m_errs  = 0;
      m_wraps = 0;
    end
  endtask

  // Drive one cycle of inputs on the falling edge and advance the model
  task automatic applyStimulus(input bit vld, input int cin, input bit clr);
    @(negedge clk);
    count_vld = vld;
    count_in  = WIDTH'(cin);
    clear     = clr;
    modelStep(vld, cin, clr);
  endtask

  // Wait for the sampling edge of the last applied stimulus, then settle
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_err_pulse"}, err_pulse, 0);
    checkOutput({tag, "_wrap_pulse"}, wrap_pulse, 0);
    checkOutput({tag, "_rst_pulse"}, rst_pulse, 0);
    checkOutput({tag, "_err_count"}, err_count, 0);
    checkOutput({tag, "_wrap_count"}, wrap_count, 0);
  endtask

  // Per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      checkOutput("cyc_locked", locked, m_locked);
      checkOutput("cyc_err_pulse", err_pulse, e_err);
      checkOutput("cyc_wrap_pulse", wrap_pulse, e_wrap);
      checkOutput("cyc_rst_pulse", rst_pulse, e_rst);
      checkOutput("cyc_err_count", err_count, clip(m_errs));
      checkOutput("cyc_wrap_count", wrap_count, clip(m_wraps));
    end
  end

  initial begin
    int ctr;
    int r;
    bit v;
    count_vld = 1'b0;
    count_in  = '0;
    clear     = 1'b0;
    reset     = 1'b0;
    modelReset();
    #1;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Lock onto 0..4
    for (int i = 0; i <= 4; i++) applyStimulus(1'b1, i, 1'b0);
    settle();
    checkOutput("t1_locked", locked, 1);
    checkOutput("t1_err_count", err_count, 0);

    // Wrap while locked
    for (int i = 5; i <= 15; i++) applyStimulus(1'b1, i, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    settle();
    checkOutput("t2_wrap_pulse", wrap_pulse, 1);
    checkOutput("t2_wrap_count", wrap_count, 1);
    checkOutput("t2_locked", locked, 1);

    // Sequence error at 5 -> 9, then relock
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, i, 1'b0);
    applyStimulus(1'b1, 9, 1'b0);
    settle();
    checkOutput("t3_err_pulse", err_pulse, 1);
    checkOutput("t3_err_count", err_count, 1);
    checkOutput("t3_locked", locked, 0);
    for (int i = 10; i <= 13; i++) applyStimulus(1'b1, i, 1'b0);
    settle();
    checkOutput("t3_relocked", locked, 1);

    // Counter restart at 7 -> 0
    for (int i = 14; i <= 15; i++) applyStimulus(1'b1, i, 1'b0);
    for (int i = 0; i <= 7; i++) applyStimulus(1'b1, i, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    settle();
    checkOutput("t4_rst_pulse", rst_pulse, 1);
    checkOutput("t4_err_count", err_count, 1);
    checkOutput("t4_locked", locked, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, i, 1'b0);
    settle();
    checkOutput("t4_relocked", locked, 1);

    // Repeated value while locked at 6
    applyStimulus(1'b1, 5, 1'b0);
    applyStimulus(1'b1, 6, 1'b0);
    applyStimulus(1'b1, 6, 1'b0);
    settle();
`ifdef COUNT_CHECK_HOLD_EN
    checkOutput("t6_hold_err_pulse", err_pulse, 0);
    checkOutput("t6_hold_locked", locked, 1);
`else
    checkOutput("t6_hold_err_pulse", err_pulse, 1);
    checkOutput("t6_hold_locked", locked, 0);
`endif

    // Saturate the error tally, then clear together with an error
    for (int k = 0; k < 300; k++) begin
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, i, 1'b0);
      applyStimulus(1'b1, 11, 1'b0);
    end
    settle();
    checkOutput("t5_err_sat", err_count, 255);
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, i, 1'b0);
    applyStimulus(1'b1, 11, 1'b1);
    settle();
    checkOutput("t5_clr_err_pulse", err_pulse, 1);
    checkOutput("t5_clr_err_count", err_count, 0);
    checkOutput("t5_clr_wrap_count", wrap_count, 0);

    // Randomized counter traffic with gaps, jumps, restarts, stalls and clears
    ctr = 0;
    for (int n = 0; n < 4000; n++) begin
      v = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 99);
      if (v) begin
        if (r < 85) ctr = (ctr + 1) % (MAXV + 1);
        else if (r < 90) ctr = $urandom_range(0, MAXV);
        else if (r < 95) ctr = 0;
      end
      applyStimulus(v, ctr, ($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i <= 15; i++) applyStimulus(1'b1, i, 1'b0);
    @(negedge clk);
    count_vld = 1'b0;
    clear     = 1'b0;
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkAllZero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 3; i <= 9; i++) applyStimulus(1'b1, i, 1'b0);
    settle();
    checkOutput("post_reset_locked", locked, 1);
    applyStimulus(1'b0, 0, 1'b0);
    settle();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
